// File: rtl/pwm_pair_gen_if.sv
// Decoder-to-PWM bus: the done strobe plus the two modulo remainders it qualifies.
interface pwm_pair_gen_if #(
  parameter int WIDTH = 7
);
  logic             enable;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;

  modport master (output enable, A, B);
  modport slave  (input  enable, A, B);
endinterface

// File: rtl/pwm_pair_gen.sv
// Two frame-synchronous PWM channels (periods PERIOD_A / PERIOD_B) whose duties are
// double-buffered so a duty change only ever takes effect at a frame boundary.
module pwm_pair_gen #(
  parameter int WIDTH    = 7,
  parameter int PERIOD_A = 80,
  parameter int PERIOD_B = 81
) (
  input  logic           clk,
  input  logic           reset,
  pwm_pair_gen_if.slave  dec,
  output logic           pwm_a,
  output logic           pwm_b,
  output logic           frame_a,
  output logic           frame_b,
  output logic           update_ack,
  output logic           running
);

  localparam logic [WIDTH-1:0] LAST_A = WIDTH'(PERIOD_A - 1);
  localparam logic [WIDTH-1:0] LAST_B = WIDTH'(PERIOD_B - 1);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_en_d;
  logic [WIDTH-1:0] r_i_a, r_i_b, w_i_a_nxt, w_i_b_nxt;
  logic [WIDTH-1:0] r_duty_a, r_duty_b, w_duty_a_nxt, w_duty_b_nxt;
  logic [WIDTH-1:0] r_shadow_a, r_shadow_b, w_shadow_a_nxt, w_shadow_b_nxt;
  logic             r_pend_a, r_pend_b, w_pend_a_nxt, w_pend_b_nxt;
  logic             r_pwm_a, r_pwm_b, r_frame_a, r_frame_b, r_ack, r_running;
  logic             w_rise, w_wrap_a, w_wrap_b, w_run_nxt, w_ack_nxt;

  assign w_rise   = dec.enable & ~r_en_d;
  assign w_wrap_a = (r_i_a == LAST_A);
  assign w_wrap_b = (r_i_b == LAST_B);

  always_comb begin
    w_state_nxt    = r_state;
    w_i_a_nxt      = r_i_a;
    w_i_b_nxt      = r_i_b;
    w_duty_a_nxt   = r_duty_a;
    w_duty_b_nxt   = r_duty_b;
    w_shadow_a_nxt = r_shadow_a;
    w_shadow_b_nxt = r_shadow_b;
    w_pend_a_nxt   = r_pend_a;
    w_pend_b_nxt   = r_pend_b;
    w_ack_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        w_i_a_nxt = '0;
        w_i_b_nxt = '0;
        if (w_rise) begin
          w_state_nxt  = RUN;
          w_duty_a_nxt = dec.A;
          w_duty_b_nxt = dec.B;
          w_ack_nxt    = 1'b1;
        end
      end
      RUN: begin
        w_i_a_nxt = w_wrap_a ? '0 : r_i_a + WIDTH'(1);
        w_i_b_nxt = w_wrap_b ? '0 : r_i_b + WIDTH'(1);
        // A fresh capture takes priority over any commit due in the same cycle.
        if (w_rise) begin
          w_shadow_a_nxt = dec.A;
          w_shadow_b_nxt = dec.B;
          w_pend_a_nxt   = 1'b1;
          w_pend_b_nxt   = 1'b1;
        end else begin
          if (w_wrap_a && r_pend_a) begin
            w_duty_a_nxt = r_shadow_a;
            w_pend_a_nxt = 1'b0;
          end
          if (w_wrap_b && r_pend_b) begin
            w_duty_b_nxt = r_shadow_b;
            w_pend_b_nxt = 1'b0;
          end
          w_ack_nxt = (r_pend_a | r_pend_b) & ~w_pend_a_nxt & ~w_pend_b_nxt;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the counters.
  assign w_run_nxt = (w_state_nxt == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_en_d     <= 1'b0;
      r_i_a      <= '0;
      r_i_b      <= '0;
      r_duty_a   <= '0;
      r_duty_b   <= '0;
      r_shadow_a <= '0;
      r_shadow_b <= '0;
      r_pend_a   <= 1'b0;
      r_pend_b   <= 1'b0;
      r_pwm_a    <= 1'b0;
      r_pwm_b    <= 1'b0;
      r_frame_a  <= 1'b0;
      r_frame_b  <= 1'b0;
      r_ack      <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_en_d     <= dec.enable;
      r_i_a      <= w_i_a_nxt;
      r_i_b      <= w_i_b_nxt;
      r_duty_a   <= w_duty_a_nxt;
      r_duty_b   <= w_duty_b_nxt;
      r_shadow_a <= w_shadow_a_nxt;
      r_shadow_b <= w_shadow_b_nxt;
      r_pend_a   <= w_pend_a_nxt;
      r_pend_b   <= w_pend_b_nxt;
      r_pwm_a    <= w_run_nxt & (w_i_a_nxt < w_duty_a_nxt);
      r_pwm_b    <= w_run_nxt & (w_i_b_nxt < w_duty_b_nxt);
      r_frame_a  <= w_run_nxt & (w_i_a_nxt == '0);
      r_frame_b  <= w_run_nxt & (w_i_b_nxt == '0);
      r_ack      <= w_ack_nxt;
      r_running  <= w_run_nxt;
    end
  end

  assign pwm_a      = r_pwm_a;
  assign pwm_b      = r_pwm_b;
  assign frame_a    = r_frame_a;
  assign frame_b    = r_frame_b;
  assign update_ack = r_ack;
  assign running    = r_running;

endmodule

// File: doc/pwm_pair_gen.md
Name: pwm_pair_gen

Overview:
- Dual-channel PWM generator for the photonic switch drivers, sitting directly downstream of the W-to-(A,B) modulo decoder.
- Consumes the decoder's two remainders (A = W mod 80, B = W mod 81) and its done strobe.
- Produces two frame-synchronous PWM waveforms: channel A with period 80 cycles and duty A, channel B with period 81 cycles and duty B.
- Duty updates are double-buffered so a new W never truncates a frame.

Parameters:
- WIDTH, 7, width of duty inputs and frame counters
- PERIOD_A, 80, channel A frame length in clk cycles (must be ≤ 2^WIDTH)
- PERIOD_B, 81, channel B frame length in clk cycles (must be ≤ 2^WIDTH)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- enable  input  1  decoder done; a rising edge means A/B are valid
- A  input  WIDTH  channel A duty in cycles
- B  input  WIDTH  channel B duty in cycles
- pwm_a  output  1  channel A PWM
- pwm_b  output  1  channel B PWM
- frame_a  output  1  one-cycle strobe on the first cycle of each channel A frame
- frame_b  output  1  one-cycle strobe on the first cycle of each channel B frame
- update_ack  output  1  one-cycle pulse when a captured A/B pair is live on both channels
- running  output  1  high in the RUN state

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0; counters, duties, shadows, pending flags and en_d cleared.
  - Takes effect immediately, including mid-frame; no partial frame completes.
- Edge detect:
  - en_d is a registered copy of enable; rise = enable & ~en_d.
  - Level-high enable never retriggers.
  - enable falling has no effect on the outputs.
- All outputs are registered.
- Frame index i_x counts 0..PERIOD_x-1, then wraps to 0.
- Outputs per channel x:
  - pwm_x = (i_x < duty_x).
  - frame_x = (i_x == 0).
  - duty_x ≥ PERIOD_x → pwm_x constantly high.
  - duty_x = 0 → pwm_x constantly low.
- States: IDLE, RUN.
  - IDLE: outputs 0, counters held at 0.
  - IDLE → RUN on a rise sampled in cycle t:
    - duty_a←A and duty_b←B directly.
    - In cycle t+1: i_a=i_b=0, running=1, frame_a=frame_b=1, update_ack=1.
  - RUN → IDLE only via reset.
- Update in RUN:
  - A rise captures shadow_a←A and shadow_b←B, and sets pend_a=pend_b=1.
  - Channel x commits duty_x←shadow_x when i_x==PERIOD_x-1 and pend_x=1, then clears pend_x. The new duty is therefore used from the next i_x==0.
  - Channels commit independently because their periods differ.
- Simultaneous events:
  - A rise in the same cycle as i_x==PERIOD_x-1: the capture wins and the commit is deferred, so the new value goes live one frame later.
  - A new rise while pends are outstanding overwrites the shadows and re-sets both pends, so an already-committed channel recommits. Only the latest pair is ever committed.
- update_ack:
  - One-cycle pulse in the cycle after the last pend clears.
  - If a new rise occurs in the same cycle as that clear, no ack is issued for the superseded pair.
- Widths: counters are WIDTH bits; comparisons are unsigned.

Test Plan:
- Reset release, enable held 0 for 200 cycles -> all outputs remain 0, running=0.
- Rise with A=20, B=5 -> running=1 next cycle; pwm_a high 20 of every 80 cycles; pwm_b high 5 of every 81 cycles; frame_a every 80, frame_b every 81; update_ack single pulse.
- In RUN, rise with A=40, B=60 at i_a=10 -> channel A uses duty 20 until its wrap and 40 thereafter; channel B switches at its own wrap; update_ack fires the cycle after the later commit.
- Rise exactly at i_a=79 -> channel A keeps its old duty for one more full frame, then switches.
- Duties A=0, B=81 -> pwm_a stuck low, pwm_b stuck high; frame strobes unaffected.
- Two rises 30 cycles apart (A=10, then A=70) before any wrap, then reset asserted mid-frame -> only 70 is ever applied and a single ack occurs; on reset all outputs drop to 0 asynchronously and the block returns to IDLE.
